// File: rtl/counter_updown_mod_pkg.sv
// Shared constants, operation encoding and sizing helpers for the
// counter_updown_mod family.
package counter_updown_mod_pkg;

  // Values accepted by the SATURATE parameter.
  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT  = 1;

  typedef enum logic [1:0] {
    OP_HOLD    = 2'd0,
    OP_LOAD    = 2'd1,
    OP_STEP_UP = 2'd2,
    OP_STEP_DN = 2'd3
  } cnt_op_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Bits needed to hold 0..n-1, never less than one so vectors stay legal.
  function automatic int range_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/counter_updown_mod_if.sv
// Control/status bundle between a counter_updown_mod and whoever drives it.
interface counter_updown_mod_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             carry;
  logic             wrapped;

  modport master (
    output en,
    output up,
    output load,
    output load_val,
    input  cnt,
    input  tc,
    input  carry,
    input  wrapped
  );

  modport slave (
    input  en,
    input  up,
    input  load,
    input  load_val,
    output cnt,
    output tc,
    output carry,
    output wrapped
  );

endinterface

// File: rtl/counter_updown_mod_tick_prescaler.sv
// Divides the enable stream by PRESCALE: tick is high on every PRESCALE-th
// enabled cycle. A synchronous clear (the parent's load) restarts the phase.
module tick_prescaler
  import counter_updown_mod_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic clr_sync,
  output logic tick
);

  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("tick_prescaler: PRESCALE must be >= 1");
    end

    if (PRESCALE == 1) begin : g_passthru
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, clr, clr_sync};
      assign tick          = en;
    end else begin : g_divide
      localparam int              PW       = range_width(PRESCALE);
      localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
      localparam logic [PW-1:0]   PRE_ONE  = PW'(1);

      logic [PW-1:0] pre_q;
      logic [PW-1:0] pre_d;

      always_comb begin
        pre_d = pre_q;
        if (clr_sync) begin
          pre_d = '0;
        end else if (en) begin
          pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
        end
      end

      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_d;
        end
      end

      assign tick = en && (pre_q == PRE_LAST);
    end
  endgenerate

endmodule

// File: rtl/counter_updown_mod.sv
// WIDTH-bit modulo-MODULUS up/down counter with clamped parallel load,
// wrap/saturate ends, enable prescaler and cascadable terminal-count carry.
module counter_updown_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = CNT_MODE_WRAP,
  parameter int PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  counter_updown_mod_if.slave  bus
);

  generate
    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
      $error("counter_updown_mod: WIDTH must be 1..31");
    end
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("counter_updown_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (SATURATE != CNT_MODE_WRAP && SATURATE != CNT_MODE_SAT) begin : g_bad_mode
      $error("counter_updown_mod: SATURATE must be 0 (wrap) or 1 (saturate)");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("counter_updown_mod: PRESCALE must be >= 1");
    end
  endgenerate

  // MODULUS-1 always fits in WIDTH bits, so every range test compares
  // against it rather than against MODULUS itself.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_MIN = '0;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam bit               SAT_EN  = (SATURATE == CNT_MODE_SAT);

  logic             tick;
  logic             step;
  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] load_clamped;
  cnt_op_e          op;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrapped_q;
  logic             wrapped_d;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .clr      (clr),
    .en       (bus.en),
    .clr_sync (bus.load),
    .tick     (tick)
  );

  assign step         = tick && !bus.load;
  assign at_max       = (cnt_q == CNT_MAX);
  assign at_min       = (cnt_q == CNT_MIN);
  assign load_clamped = (bus.load_val > CNT_MAX) ? CNT_MAX : bus.load_val;

  always_comb begin
    op = OP_HOLD;
    if (bus.load) begin
      op = OP_LOAD;
    end else if (step) begin
      op = bus.up ? OP_STEP_UP : OP_STEP_DN;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    wrapped_d = 1'b0;
    case (op)
      OP_LOAD: begin
        cnt_d = load_clamped;
      end
      OP_STEP_UP: begin
        if (!at_max) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (!SAT_EN) begin
          cnt_d     = CNT_MIN;
          wrapped_d = 1'b1;
        end
      end
      OP_STEP_DN: begin
        if (!at_min) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!SAT_EN) begin
          cnt_d     = CNT_MAX;
          wrapped_d = 1'b1;
        end
      end
      default: begin
        cnt_d     = cnt_q;
        wrapped_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q     <= '0;
      wrapped_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wrapped_q <= wrapped_d;
    end
  end

  // tc/carry stay combinational so a chained stage sees carry in the same cycle.
  assign bus.cnt     = cnt_q;
  assign bus.wrapped = wrapped_q;
  assign bus.tc      = (bus.up && at_max) || (!bus.up && at_min);
  assign bus.carry   = bus.tc && step;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: wrap/saturate ends, clamped load,
// prescaler phase, asynchronous clear and a two-stage decimal cascade.
module tb_counter_updown_mod;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  counter_updown_mod_if #(.WIDTH(4)) if_a  ();
  counter_updown_mod_if #(.WIDTH(4)) if_b  ();
  counter_updown_mod_if #(.WIDTH(4)) if_c  ();
  counter_updown_mod_if #(.WIDTH(4)) if_d0 ();
  counter_updown_mod_if #(.WIDTH(4)) if_d1 ();

  counter_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1))
    u_a  (.clk(clk), .clr(clr), .bus(if_a));
  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1))
    u_b  (.clk(clk), .clr(clr), .bus(if_b));
  counter_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(3))
    u_c  (.clk(clk), .clr(clr), .bus(if_c));
  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1))
    u_d0 (.clk(clk), .clr(clr), .bus(if_d0));
  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1))
    u_d1 (.clk(clk), .clr(clr), .bus(if_d1));

  assign if_d1.en = if_d0.carry;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_clr();
    @(posedge clk);
    #1;
    clr = 1'b1;
    #2;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    if_a.en = 1'b1;
    if_a.up = 1'b1;
    #3;
    checks++;
    if (if_a.cnt !== 4'd0 || if_b.cnt !== 4'd0 || if_c.cnt !== 4'd0 || if_d0.cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_cnt got a=%0d b=%0d c=%0d d0=%0d exp=0", if_a.cnt, if_b.cnt, if_c.cnt, if_d0.cnt);
    end
    tick();
    checks++;
    if (if_a.cnt !== 4'd0 || if_a.wrapped !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got cnt=%0d wrapped=%0b exp cnt=0 wrapped=0", if_a.cnt, if_a.wrapped);
    end
    $display("reset: cnt=%0d wrapped=%0b", if_a.cnt, if_a.wrapped);
    if_a.en = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_count_wrap();
    int exp_cnt;
    apply_clr();
    if_a.en = 1'b1;
    if_a.up = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_cnt = k % 16;
      checks++;
      if (if_a.cnt !== 4'(exp_cnt)) begin
        failures++;
        $display("FAIL wrap_cnt k=%0d got=%0d exp=%0d", k, if_a.cnt, exp_cnt);
      end
      checks++;
      if (if_a.wrapped !== (k == 16)) begin
        failures++;
        $display("FAIL wrap_pulse k=%0d got=%0b exp=%0b", k, if_a.wrapped, (k == 16));
      end
      checks++;
      if (if_a.carry !== (exp_cnt == 15)) begin
        failures++;
        $display("FAIL wrap_carry k=%0d got=%0b exp=%0b", k, if_a.carry, (exp_cnt == 15));
      end
      $display("count_wrap k=%0d cnt=%0d wrapped=%0b carry=%0b", k, if_a.cnt, if_a.wrapped, if_a.carry);
    end
    if_a.en = 1'b0;
  endtask

  task automatic test_down_wrap();
    apply_clr();
    if_a.en = 1'b1;
    if_a.up = 1'b0;
    #1;
    checks++;
    if (if_a.tc !== 1'b1 || if_a.carry !== 1'b1) begin
      failures++;
      $display("FAIL down_tc got tc=%0b carry=%0b exp tc=1 carry=1", if_a.tc, if_a.carry);
    end
    tick();
    checks++;
    if (if_a.cnt !== 4'd15 || if_a.wrapped !== 1'b1) begin
      failures++;
      $display("FAIL down_wrap got cnt=%0d wrapped=%0b exp cnt=15 wrapped=1", if_a.cnt, if_a.wrapped);
    end
    tick();
    checks++;
    if (if_a.cnt !== 4'd14 || if_a.wrapped !== 1'b0) begin
      failures++;
      $display("FAIL down_step got cnt=%0d wrapped=%0b exp cnt=14 wrapped=0", if_a.cnt, if_a.wrapped);
    end
    if_a.en = 1'b0;
    tick();
    checks++;
    if (if_a.cnt !== 4'd14 || if_a.carry !== 1'b0) begin
      failures++;
      $display("FAIL down_hold got cnt=%0d carry=%0b exp cnt=14 carry=0", if_a.cnt, if_a.carry);
    end
    $display("down_wrap: cnt=%0d", if_a.cnt);
  endtask

  task automatic test_saturate();
    int exp_cnt;
    apply_clr();
    if_b.en = 1'b1;
    if_b.up = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (if_b.cnt !== 4'd0 || if_b.wrapped !== 1'b0 || if_b.tc !== 1'b1) begin
        failures++;
        $display("FAIL sat_low k=%0d got cnt=%0d wrapped=%0b tc=%0b exp 0/0/1", k, if_b.cnt, if_b.wrapped, if_b.tc);
      end
    end
    if_b.up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_cnt = (k < 9) ? k : 9;
      checks++;
      if (if_b.cnt !== 4'(exp_cnt) || if_b.wrapped !== 1'b0) begin
        failures++;
        $display("FAIL sat_up k=%0d got cnt=%0d wrapped=%0b exp cnt=%0d wrapped=0", k, if_b.cnt, if_b.wrapped, exp_cnt);
      end
      $display("saturate k=%0d cnt=%0d tc=%0b", k, if_b.cnt, if_b.tc);
    end
    checks++;
    if (if_b.tc !== 1'b1 || if_b.carry !== 1'b1) begin
      failures++;
      $display("FAIL sat_tc got tc=%0b carry=%0b exp tc=1 carry=1", if_b.tc, if_b.carry);
    end
  endtask

  task automatic test_load();
    if_b.en       = 1'b1;
    if_b.up       = 1'b1;
    if_b.load     = 1'b1;
    if_b.load_val = 4'd7;
    #1;
    checks++;
    if (if_b.tc !== 1'b1 || if_b.carry !== 1'b0) begin
      failures++;
      $display("FAIL load_carry got tc=%0b carry=%0b exp tc=1 carry=0", if_b.tc, if_b.carry);
    end
    tick();
    checks++;
    if (if_b.cnt !== 4'd7) begin
      failures++;
      $display("FAIL load_7 got=%0d exp=7", if_b.cnt);
    end
    if_b.load_val = 4'd12;
    tick();
    checks++;
    if (if_b.cnt !== 4'd9) begin
      failures++;
      $display("FAIL load_clamp12 got=%0d exp=9", if_b.cnt);
    end
    if_b.load_val = 4'd0;
    tick();
    if_b.load_val = 4'd15;
    tick();
    checks++;
    if (if_b.cnt !== 4'd9) begin
      failures++;
      $display("FAIL load_clamp15 got=%0d exp=9", if_b.cnt);
    end
    if_b.load_val = 4'd3;
    tick();
    if_b.load = 1'b0;
    tick();
    checks++;
    if (if_b.cnt !== 4'd4) begin
      failures++;
      $display("FAIL load_then_step got=%0d exp=4", if_b.cnt);
    end
    $display("load: cnt=%0d", if_b.cnt);
    if_b.en = 1'b0;
  endtask

  task automatic test_prescale();
    int enabled;
    apply_clr();
    enabled = 0;
    if_c.up = 1'b1;
    if_c.en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      enabled++;
      checks++;
      if (if_c.cnt !== 4'(enabled / 3)) begin
        failures++;
        $display("FAIL pre_run k=%0d got=%0d exp=%0d", k, if_c.cnt, enabled / 3);
      end
    end
    if_c.en = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if (if_c.cnt !== 4'd2 || if_c.carry !== 1'b0) begin
        failures++;
        $display("FAIL pre_pause k=%0d got cnt=%0d carry=%0b exp cnt=2 carry=0", k, if_c.cnt, if_c.carry);
      end
    end
    if_c.en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      enabled++;
      checks++;
      if (if_c.cnt !== 4'(enabled / 3)) begin
        failures++;
        $display("FAIL pre_resume k=%0d got=%0d exp=%0d", k, if_c.cnt, enabled / 3);
      end
      $display("prescale enabled=%0d cnt=%0d", enabled, if_c.cnt);
    end
    if_c.load     = 1'b1;
    if_c.load_val = 4'd5;
    tick();
    if_c.load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (if_c.cnt !== ((k == 3) ? 4'd6 : 4'd5)) begin
        failures++;
        $display("FAIL pre_after_load k=%0d got=%0d exp=%0d", k, if_c.cnt, (k == 3) ? 6 : 5);
      end
    end
    if_c.en = 1'b0;
  endtask

  task automatic test_async_clr();
    apply_clr();
    if_a.en = 1'b1;
    if_a.up = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    checks++;
    if (if_a.cnt !== 4'd5) begin
      failures++;
      $display("FAIL aclr_pre got=%0d exp=5", if_a.cnt);
    end
    if_a.en = 1'b0;
    #3;
    clr = 1'b1;
    #1;
    checks++;
    if (if_a.cnt !== 4'd0) begin
      failures++;
      $display("FAIL aclr_now got=%0d exp=0", if_a.cnt);
    end
    #1;
    clr     = 1'b0;
    if_a.en = 1'b1;
    tick();
    checks++;
    if (if_a.cnt !== 4'd1) begin
      failures++;
      $display("FAIL aclr_resume got=%0d exp=1", if_a.cnt);
    end
    $display("async_clr: cnt=%0d", if_a.cnt);
    if_a.en = 1'b0;
  endtask

  task automatic test_cascade();
    int got;
    int wraps1;
    int wraps0;
    apply_clr();
    wraps0   = 0;
    wraps1   = 0;
    if_d0.up = 1'b1;
    if_d1.up = 1'b1;
    if_d0.en = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      tick();
      got = int'(if_d1.cnt) * 10 + int'(if_d0.cnt);
      if (if_d0.wrapped === 1'b1) wraps0++;
      if (if_d1.wrapped === 1'b1) wraps1++;
      checks++;
      if (got !== (k % 100)) begin
        failures++;
        $display("FAIL cascade_val k=%0d got=%0d exp=%0d", k, got, k % 100);
      end
      $display("cascade k=%0d value=%0d", k, got);
    end
    checks++;
    if (wraps1 !== 1 || wraps0 !== 10) begin
      failures++;
      $display("FAIL cascade_wraps got s1=%0d s0=%0d exp s1=1 s0=10", wraps1, wraps0);
    end
    if_d0.en = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr      = 1'b1;
    if_a.en = 1'b0; if_a.up = 1'b1; if_a.load = 1'b0; if_a.load_val = '0;
    if_b.en = 1'b0; if_b.up = 1'b1; if_b.load = 1'b0; if_b.load_val = '0;
    if_c.en = 1'b0; if_c.up = 1'b1; if_c.load = 1'b0; if_c.load_val = '0;
    if_d0.en = 1'b0; if_d0.up = 1'b1; if_d0.load = 1'b0; if_d0.load_val = '0;
    if_d1.up = 1'b1; if_d1.load = 1'b0; if_d1.load_val = '0;

    test_reset();
    test_count_wrap();
    test_down_wrap();
    test_saturate();
    test_load();
    test_prescale();
    test_async_clr();
    test_cascade();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
